mem_bus_arbiter: RTL

//  Parametrised memory-bus arbiter and address decoder between NUM_MASTERS byte-wide requesters
//  (master 0 = debug/HCI, others = CPU ports) and the shared RAM and memory-mapped IO targets.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory-bus arbiter: master 0 has fixed priority, the other masters share the bus round-robin, and accesses are decoded to RAM or IO.
// Latency: grant 1 cycle after request, ack same cycle as issue, read data 1 cycle after issue. A stalled IO write holds ack low.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 17,
    parameter int MAX_BURST   = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_wr,
    input  logic [32*NUM_MASTERS-1:0]   m_a,
    input  logic [8*NUM_MASTERS-1:0]    m_dout,
    output logic [NUM_MASTERS-1:0]      m_gnt,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [7:0]                  m_din,
    output logic [NUM_MASTERS-1:0]      m_rvalid,
    output logic                        ram_en,
    output logic                        ram_wr,
    output logic [ADDR_WIDTH-1:0]       ram_a,
    output logic [7:0]                  ram_dout,
    input  logic [7:0]                  ram_din,
    output logic                        io_en,
    output logic                        io_wr,
    output logic [2:0]                  io_sel,
    output logic [7:0]                  io_dout,
    input  logic [7:0]                  io_din,
    input  logic                        io_full
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_holder, w_holder_nxt;
    logic [IW-1:0]          r_rr_ptr, w_rr_nxt;
    logic [BW-1:0]          r_burst, w_burst_nxt;
    logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
    logic                   r_q_pend;
    logic                   r_q_io;
    logic [IW-1:0]          r_q_mst;

    logic [ADDR_WIDTH:0]    w_a;
    logic [7:0]             w_dout;
    logic                   w_req, w_wr, w_io, w_issue, w_preempt, w_last, w_release;
    logic [IW-1:0]          w_pick, w_rr_adv;
    logic                   w_found;
    int                     w_idx;
    logic                   w_unused;

    assign w_unused = ^m_a;

    assign w_a    = m_a[32*int'(r_holder) +: ADDR_WIDTH+1];
    assign w_dout = m_dout[8*int'(r_holder) +: 8];
    assign w_req  = m_req[r_holder];
    assign w_wr   = m_wr[r_holder];
    assign w_io   = (w_a[ADDR_WIDTH -: 2] == 2'b11);

    // A full IO buffer blocks only IO writes. IO reads and RAM accesses still issue.
    assign w_issue = (r_state == ST_OWN) & w_req & rdy_in & ~(w_io & w_wr & io_full);
    assign w_last  = w_issue & (r_burst == BW'(MAX_BURST - 1));

    generate
        if (NUM_MASTERS > 1) begin : g_preempt
            assign w_preempt = (r_state == ST_OWN) & m_req[0] & (r_holder != '0);
        end else begin : g_no_preempt
            assign w_preempt = 1'b0;
        end
    endgenerate

    assign w_release = ~w_req | w_last | w_preempt;
    assign w_rr_adv  = (r_holder == IW'(NUM_MASTERS - 1)) ? IW'(1) : r_holder + IW'(1);

    // Master 0 wins outright. The round-robin scan starts at rr_ptr and covers masters 1..N-1.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (!m_req[0]) begin
            for (int k = 0; k < NUM_MASTERS - 1; k++) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx > NUM_MASTERS - 1) w_idx = w_idx - (NUM_MASTERS - 1);
                if (!w_found && m_req[w_idx]) begin
                    w_found = 1'b1;
                    w_pick  = IW'(w_idx);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_holder_nxt = r_holder;
        w_rr_nxt     = r_rr_ptr;
        w_burst_nxt  = r_burst;
        w_gnt_nxt    = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (|m_req) begin
                    w_state_nxt  = ST_OWN;
                    w_holder_nxt = w_pick;
                    w_gnt_nxt    = NUM_MASTERS'(1) << w_pick;
                end
            end
            ST_OWN: begin
                if (w_issue) w_burst_nxt = r_burst + BW'(1);
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_burst_nxt = '0;
                    if (r_holder != '0) w_rr_nxt = w_rr_adv;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_holder <= '0;
            r_rr_ptr <= IW'(1);
            r_burst  <= '0;
            r_gnt    <= '0;
            r_q_pend <= 1'b0;
            r_q_io   <= 1'b0;
            r_q_mst  <= '0;
        end else begin
            if (rdy_in) begin
                r_state  <= w_state_nxt;
                r_holder <= w_holder_nxt;
                r_rr_ptr <= w_rr_nxt;
                r_burst  <= w_burst_nxt;
                r_gnt    <= w_gnt_nxt;
            end
            // The read-return tag updates even while rdy_in is low, so a return in flight still completes.
            r_q_pend <= w_issue & ~w_wr;
            if (w_issue & ~w_wr) begin
                r_q_io  <= w_io;
                r_q_mst <= r_holder;
            end
        end
    end

    assign m_gnt    = r_gnt;
    assign m_ack    = w_issue ? (NUM_MASTERS'(1) << r_holder) : '0;
    assign m_rvalid = r_q_pend ? (NUM_MASTERS'(1) << r_q_mst) : '0;
    assign m_din    = r_q_io ? io_din : ram_din;

    assign ram_en   = w_issue & ~w_io;
    assign ram_wr   = ram_en & w_wr;
    assign ram_a    = w_a[ADDR_WIDTH-1:0];
    assign ram_dout = w_dout;

    assign io_en    = w_issue & w_io;
    assign io_wr    = io_en & w_wr;
    assign io_sel   = w_a[2:0];
    assign io_dout  = w_dout;

endmodule
